// File: rtl/quant_scheduler_if.sv
// quant_scheduler_if: accumulator stream, quantizer parameter bus and credit return
interface quant_scheduler_if;
  logic [31:0] acc_data;
  logic        acc_valid;
  logic        acc_ready;
  logic [31:0] q_data;
  logic        q_valid;
  logic [31:0] q_m;
  logic [4:0]  q_n;
  logic        q_relu;
  logic        q_valid_out;
  logic        credit_return;
  modport master (
    output acc_data, acc_valid, q_valid_out, credit_return,
    input  acc_ready, q_data, q_valid, q_m, q_n, q_relu
  );
  modport slave (
    input  acc_data, acc_valid, q_valid_out, credit_return,
    output acc_ready, q_data, q_valid, q_m, q_n, q_relu
  );
endinterface

// File: rtl/quant_scheduler.sv
// quant_scheduler: issues accumulators with per-channel quant parameters under credit flow control
module quant_scheduler #(
  parameter int CH_DEPTH = 256,
  parameter int CREDITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_m,
  input  logic [4:0]  cfg_n,
  input  logic        cfg_relu,
  input  logic        start,
  input  logic [8:0]  num_ch,
  input  logic [15:0] num_pix,
  output logic        busy,
  output logic        done,
  output logic        err,
  quant_scheduler_if.slave bus
);
  localparam int AW = CH_DEPTH > 1 ? $clog2(CH_DEPTH) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] m;
    logic [4:0]  n;
    logic        relu;
  } entry_t;
  state_t        state;
  entry_t        tbl [CH_DEPTH];
  entry_t        cur;
  logic [AW-1:0] ch, last_ch;
  logic [24:0]   total, issued, retired;
  logic [CW-1:0] credits;
  logic [4:0]    n_pipe;
  logic          n_valid, issue, start_ok;
  assign bus.acc_ready = state == RUN && credits != '0;
  assign issue = bus.acc_valid && bus.acc_ready;
  assign start_ok = num_ch != 9'd0 && num_ch <= 9'(CH_DEPTH) && num_pix != 16'd0;
  assign cur = tbl[ch];
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < CH_DEPTH; i++) tbl[i] <= '0;
    else if (cfg_we && state == IDLE && {1'b0, cfg_addr} < 9'(CH_DEPTH))
      tbl[cfg_addr[AW-1:0]] <= {cfg_m, cfg_n, cfg_relu};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      bus.q_valid <= 1'b0;
      bus.q_data  <= '0;
      bus.q_m     <= '0;
      bus.q_n     <= '0;
      bus.q_relu  <= 1'b0;
      n_pipe      <= '0;
      n_valid     <= 1'b0;
      ch          <= '0;
      last_ch     <= '0;
      total       <= '0;
      issued      <= '0;
      retired     <= '0;
      credits     <= CW'(CREDITS);
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      bus.q_valid <= issue;
      n_valid     <= issue;
      if (issue) begin
        bus.q_data <= bus.acc_data;
        bus.q_m    <= cur.m;
        bus.q_relu <= cur.relu;
        n_pipe     <= cur.n;
        ch         <= ch == last_ch ? '0 : ch + 1'b1;
        issued     <= issued + 25'd1;
      end
      // shift lands one cycle after the multiplier to match the quantizer's second stage
      if (n_valid) bus.q_n <= n_pipe;
      if (state != IDLE && bus.q_valid_out) retired <= retired + 25'd1;
      if (issue && !bus.credit_return) credits <= credits - 1'b1;
      else if (!issue && bus.credit_return && credits != CW'(CREDITS)) credits <= credits + 1'b1;
      case (state)
        IDLE:
          if (start && start_ok) begin
            state   <= RUN;
            busy    <= 1'b1;
            last_ch <= AW'(num_ch - 9'd1);
            total   <= 25'(num_ch) * 25'(num_pix);
            issued  <= '0;
            retired <= '0;
            ch      <= '0;
            credits <= CW'(CREDITS);
          end else if (start) err <= 1'b1;
        RUN:
          if (issue && issued + 25'd1 == total) state <= DRAIN;
        default:
          if (retired == total) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
      endcase
    end
  end
endmodule

// File: doc/quant_scheduler.md
QUANT_SCHEDULER -- requirements
Module: quant_scheduler

Interface
REQ-001 SHALL have parameter CH_DEPTH, default 256, the number of per-channel parameter table entries.
REQ-002 SHALL have parameter CREDITS, default 8, the number of downstream buffer slots available at start.
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: cfg_we  in  1  table write strobe; cfg_addr  in  8  channel index; cfg_m  in  32  multiplier; cfg_n  in  5  shift; cfg_relu  in  1  leaky-ReLU enable.
REQ-005 SHALL have ports: start  in  1  job start pulse; num_ch  in  9  channels per pixel (1..CH_DEPTH); num_pix  in  16  pixels per job (>=1).
REQ-006 SHALL have ports: busy  out  1  job active; done  out  1  one-cycle job-complete pulse; err  out  1  one-cycle rejected-start pulse.
REQ-007 SHALL have ports: acc_data  in  32  signed accumulator value; acc_valid  in  1; acc_ready  out  1.
REQ-008 SHALL have ports: q_data  out  32; q_valid  out  1; q_m  out  32; q_n  out  5; q_relu  out  1 (all to quantizer); q_valid_out  in  1 (from quantizer output).
REQ-009 SHALL have port credit_return  in  1, a one-cycle pulse when downstream frees one slot.

Function
REQ-010 SHALL hold a CH_DEPTH-entry table of {M, n, relu}; cfg_we writes entry cfg_addr in IDLE only; writes in any other state SHALL be ignored.
REQ-011 SHALL implement states IDLE, RUN, DRAIN.
REQ-012 IDLE -> RUN on start when 1 <= num_ch <= CH_DEPTH and num_pix >= 1; the job SHALL latch num_ch, num_pix, set total = num_ch*num_pix (25-bit), clear issued/retired counters, set channel index to 0, and load credit counter to CREDITS.
REQ-013 start with invalid num_ch or num_pix = 0 SHALL pulse err for one cycle and remain IDLE; start outside IDLE SHALL be ignored with no err.
REQ-014 acc_ready SHALL equal (state == RUN) and (credits > 0); it SHALL not depend on acc_valid.
REQ-015 An issue occurs on a cycle with acc_valid and acc_ready; on issue the channel index increments, wrapping from num_ch-1 to 0, and issued increments.
REQ-016 Issue at cycle t SHALL produce at t+1: q_valid = 1, q_data = acc_data, q_m and q_relu = table[channel index at t]; q_valid SHALL be 0 in cycles without a preceding issue.
REQ-017 q_n SHALL present table[channel index at t].n at cycle t+2 (one cycle after q_m), matching the quantizer's one-stage-later shift; q_n SHALL hold its value in cycles with no issue two cycles prior.
REQ-018 Credits SHALL decrement on issue, increment on credit_return, stay unchanged when both occur, and saturate at CREDITS (extra returns ignored).
REQ-019 RUN -> DRAIN on the cycle issued reaches total; no further issues in DRAIN.
REQ-020 retired SHALL increment on each q_valid_out while busy; q_valid_out in IDLE SHALL be ignored.
REQ-021 DRAIN -> IDLE when retired == total; done SHALL pulse for exactly that cycle's following cycle, coincident with busy falling.
REQ-022 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-023 If retired reaches total in the same cycle issued reaches total (not possible under correct quantizer latency), the block SHALL still transit via DRAIN for one cycle before done.
REQ-024 Table contents SHALL be readable in the same cycle they were written only in IDLE; job behaviour SHALL use the table as of the start cycle and thereafter.

Reset
REQ-025 On rst_n low at a clock edge: state IDLE; busy, done, err, q_valid, acc_ready = 0; q_data, q_m, q_n, q_relu = 0; counters and channel index = 0; credits = CREDITS; all table entries = 0.
REQ-026 Reset asserted mid-job SHALL abort the job with no done pulse; in-flight quantizer outputs after reset SHALL be ignored.

Verification
REQ-027 Table ch0={M=3,n=1,relu=0}, ch1={M=5,n=2,relu=1}; start num_ch=2,num_pix=2; feed 4 values back-to-back -> q_m sequence 3,5,3,5 at t+1, q_n 1,2,1,2 at t+2, done after 4th q_valid_out.
REQ-028 CREDITS=8, no credit_return, 10 inputs offered -> exactly 8 issues, acc_ready=0 thereafter; one credit_return -> exactly one more issue.
REQ-029 credit_return and issue in the same cycle with credits=1 -> credits stays 1, acc_ready remains 1.
REQ-030 start with num_ch=0, then num_ch=257 -> err pulse each, busy stays 0; cfg_we during RUN to ch0 -> ch0 M unchanged in next job.
REQ-031 num_ch=256,num_pix=1 -> channel index wraps 255 -> 0 only once; done after 256 q_valid_out.
REQ-032 rst_n low during RUN after 3 of 8 issues -> next cycle busy=0, q_valid=0, credits=CREDITS, no done; new job then completes normally.
